// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master Wishbone arbiter in front of the on-chip RAM
// wrapper. Master 0 is the instruction port, master 1 the data port.
// Grants round-robin, one transaction per grant, with a one-cycle GAP after
// every grant so the RAM always sees a fresh cyc/stb rising edge.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that errors a
// granted transaction after TIMEOUT_CYCLES cycles without s_ack_i. Without the
// macro there is no counter, the err outputs are constant 0 and the arbiter
// waits for the ack indefinitely.

module wb_ram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  // master 0 (instruction)
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1 (data)
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // slave (RAM wrapper)
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i
);

  // Elaboration-time range check on the timeout length.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_ram_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  // One master's request bundle, so the granted master is a single mux.
  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t m0_req, m1_req, gnt_req;
  logic    req0, req1;
  state_t  state_q, state_d;
  logic    last_grant_q;   // 0: master 0 was granted last, 1: master 1
  logic    granted;
  logic    timeout_hit;

  assign m0_req  = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i};
  assign m1_req  = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i};
  assign req0    = m0_cyc_i & m0_stb_i;
  assign req1    = m1_cyc_i & m1_stb_i;
  assign gnt_req = (state_q == GNT1) ? m1_req : m0_req;
  assign granted = (state_q == GNT0) || (state_q == GNT1);

  // Read data is broadcast; only the granted master gets an ack to qualify it.
  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;

  // State register and round-robin history.
  // NOTE: sequential state uses non-blocking assignments under an async
  // active-low reset, so every register updates from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;   // master 0 wins the first tie
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d == GNT0) last_grant_q <= 1'b0;
      if (state_q == IDLE && state_d == GNT1) last_grant_q <= 1'b1;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;

  // Counts granted cycles without ack; held at zero outside a grant so each
  // grant starts counting from zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      to_cnt_q <= '0;
    end else if (granted && !s_ack_i) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_hit = (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state decode and all slave/master return signalling.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_addr_o = '0;
    s_data_o = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_err_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 && (!req1 || last_grant_q)) state_d = GNT0;
        else if (req1)                       state_d = GNT1;
      end

      GNT0, GNT1: begin
        s_cyc_o  = gnt_req.cyc & gnt_req.stb;
        s_stb_o  = gnt_req.cyc & gnt_req.stb;
        s_we_o   = gnt_req.we;
        s_sel_o  = gnt_req.sel;
        s_addr_o = gnt_req.addr;
        s_data_o = gnt_req.data;
        if (state_q == GNT0) m0_ack_o = s_ack_i;
        else                 m1_ack_o = s_ack_i;

        // Ack wins over a simultaneous abort; an abort suppresses the timeout.
        if (s_ack_i || !gnt_req.cyc) begin
          state_d = GAP;
        end else if (timeout_hit) begin
          state_d = GAP;
          if (state_q == GNT0) m0_err_o = 1'b1;
          else                 m1_err_o = 1'b1;
        end
      end

      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter (TIMEOUT_CYCLES = 8). Inputs change 1 ns
// after the rising edge, outputs are sampled on the falling edge. A small RAM
// model acks one cycle after it sees s_stb_o and returns addr ^ 0xA5A5_0000.

module tb_wb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i;
  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o, s_data_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i;

  logic        slave_auto, auto_ack, man_ack;
  logic [31:0] auto_data, man_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  wb_ram_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i)
  );

  // RAM model: one ack per request, one cycle after stb is seen.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      auto_ack  <= 1'b0;
      auto_data <= '0;
    end else begin
      auto_ack  <= slave_auto && s_stb_o && !auto_ack;
      auto_data <= s_addr_o ^ 32'hA5A5_0000;
    end
  end

  assign s_ack_i  = slave_auto ? auto_ack  : man_ack;
  assign s_data_i = slave_auto ? auto_data : man_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one master's request; the idle master carries junk with cyc low.
  task automatic set_master(input logic mst, input logic en, input logic we,
                            input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] data);
    if (mst == 1'b0) begin
      {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_addr_i, m0_data_i} = {en, en, we, sel, addr, data};
    end else begin
      {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_addr_i, m1_data_i} = {en, en, we, sel, addr, data};
    end
  endtask

  typedef struct {
    string       name;
    logic        mst;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_m0_ack;
    logic        exp_m1_ack;
  } vec_t;

  vec_t vecs[4];

  // One complete single-master transaction against the RAM model.
  task automatic run_vec(input vec_t v);
    @(posedge clk_i); #1;
    set_master(v.mst, 1'b1, v.we, v.sel, v.addr, v.wdata);
    {m1_cyc_i, m1_stb_i} = v.mst ? 2'b11 : 2'b00;
    {m0_cyc_i, m0_stb_i} = v.mst ? 2'b01 : 2'b11;  // idle master: stb without cyc
    if (v.mst) {m0_we_i, m0_sel_i, m0_addr_i, m0_data_i} = {1'b1, 4'hF, ~v.addr, ~v.wdata};
    else       {m1_we_i, m1_sel_i, m1_addr_i, m1_data_i} = {1'b1, 4'hF, ~v.addr, ~v.wdata};
    @(negedge clk_i);
    check({v.name, ".idle_stb"}, 32'(s_stb_o), 32'd0);
    @(negedge clk_i);
    check({v.name, ".cyc_stb"}, 32'({s_cyc_o, s_stb_o}), 32'd3);
    check({v.name, ".we"},   32'(s_we_o), 32'(v.we));
    check({v.name, ".sel"},  32'(s_sel_o), 32'(v.sel));
    check({v.name, ".addr"}, s_addr_o, v.addr);
    check({v.name, ".data"}, s_data_o, v.wdata);
    check({v.name, ".early_ack"}, 32'({m0_ack_o, m1_ack_o}), 32'd0);
    @(negedge clk_i);
    check({v.name, ".ack"}, 32'({m0_ack_o, m1_ack_o}), 32'({v.exp_m0_ack, v.exp_m1_ack}));
    check({v.name, ".m0_rdata"}, m0_data_o, v.exp_rdata);
    check({v.name, ".m1_rdata"}, m1_data_o, v.exp_rdata);
    @(posedge clk_i); #1;
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = '0;
    @(negedge clk_i);
    check({v.name, ".gap"}, 32'({s_cyc_o, s_stb_o}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int  nacks, c0, c1, nrise, first_err, n_err, n_low, n_ack;
    int  rise[2];
    logic order[8];
    logic prev_stb;

    vecs[0] = '{name:"rd_m0",   mst:1'b0, we:1'b0, sel:4'hF, addr:32'h0000_0010,
                wdata:32'h0,          exp_rdata:32'hA5A5_0010, exp_m0_ack:1'b1, exp_m1_ack:1'b0};
    vecs[1] = '{name:"wr_m1",   mst:1'b1, we:1'b1, sel:4'b0011, addr:32'h0000_0104,
                wdata:32'hDEAD_BEEF, exp_rdata:32'hA5A5_0104, exp_m0_ack:1'b0, exp_m1_ack:1'b1};
    vecs[2] = '{name:"wr_m0",   mst:1'b0, we:1'b1, sel:4'b1000, addr:32'hFFFF_FFFC,
                wdata:32'h1234_5678, exp_rdata:32'h5A5A_FFFC, exp_m0_ack:1'b1, exp_m1_ack:1'b0};
    vecs[3] = '{name:"rd_m1",   mst:1'b1, we:1'b0, sel:4'hF, addr:32'h8000_0000,
                wdata:32'h0,          exp_rdata:32'h25A5_0000, exp_m0_ack:1'b0, exp_m1_ack:1'b1};

    // Reset with a request and an ack already present: everything stays 0.
    rst_n_i = 1'b0; slave_auto = 1'b0; man_ack = 1'b1; man_data = 32'h1111_2222;
    set_master(1'b0, 1'b1, 1'b1, 4'hF, 32'h0000_0010, 32'h5555_AAAA);
    set_master(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk_i);
    check("rst.s_ctrl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
    check("rst.s_addr", s_addr_o, 32'd0);
    check("rst.s_data", s_data_o, 32'd0);
    check("rst.ack_err", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    {m0_cyc_i, m0_stb_i} = 2'b00;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    check("idle.ack_ignored", 32'({m0_ack_o, m1_ack_o}), 32'd0);
    man_ack = 1'b0;

    // Tie after reset plus sustained contention: 4 transactions per master.
    slave_auto = 1'b1;
    @(posedge clk_i); #1;
    set_master(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    set_master(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    nacks = 0; c0 = 0; c1 = 0; nrise = 0; prev_stb = 1'b0; rise = '{0, 0};
    for (int i = 0; i < 200 && nacks < 8; i++) begin
      @(negedge clk_i);
      if (s_stb_o && !prev_stb && nrise < 2) begin rise[nrise] = i; nrise++; end
      prev_stb = s_stb_o;
      if (m0_ack_o && nacks < 8) begin order[nacks] = 1'b0; nacks++; c0++; end
      if (m1_ack_o && nacks < 8) begin order[nacks] = 1'b1; nacks++; c1++; end
      @(posedge clk_i); #1;
      if (c0 >= 4) {m0_cyc_i, m0_stb_i} = 2'b00;
      if (c1 >= 4) {m1_cyc_i, m1_stb_i} = 2'b00;
    end
    check("rr.ack_count", 32'(nacks), 32'd8);
    check("rr.stb_spacing", 32'(rise[1] - rise[0]), 32'd4);
    for (int i = 0; i < 8; i++) check($sformatf("rr.order%0d", i), 32'(order[i]), 32'(i % 2));

    // Table of single transactions.
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Abort one cycle into the grant, then m1 must be served from IDLE.
    slave_auto = 1'b0; man_ack = 1'b0; man_data = 32'hCAFE_F00D;
    @(posedge clk_i); #1;
    set_master(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0030, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    check("abort.granted", 32'(s_stb_o), 32'd1);
    @(posedge clk_i); #1;
    m0_cyc_i = 1'b0;
    @(negedge clk_i);
    check("abort.s_drop", 32'({s_cyc_o, s_stb_o}), 32'd0);
    check("abort.no_ack_err", 32'({m0_ack_o, m0_err_o}), 32'd0);
    @(posedge clk_i); #1;
    m0_stb_i = 1'b0;
    set_master(1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0);
    @(negedge clk_i);
    check("abort.gap", 32'(s_stb_o), 32'd0);
    @(negedge clk_i);
    check("abort.idle", 32'(s_stb_o), 32'd0);
    @(negedge clk_i);
    check("abort.m1_grant", s_addr_o, 32'h0000_0040);

    // Reset mid-grant with the ack already up: outputs drop at once.
    man_ack = 1'b1;
    #1;
    check("rstmid.ack_before", 32'({m0_ack_o, m1_ack_o}), 32'd1);
    check("rstmid.rdata", m1_data_o, 32'hCAFE_F00D);
    rst_n_i = 1'b0;
    #1;
    check("rstmid.s_ctrl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
    check("rstmid.s_addr", s_addr_o, 32'd0);
    check("rstmid.ack_err", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
    man_ack = 1'b0;
    {m1_cyc_i, m1_stb_i} = 2'b00;
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Slave never acks.
    @(posedge clk_i); #1;
    set_master(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0050, 32'h0);
    @(negedge clk_i);
    first_err = 0; n_err = 0; n_low = 0; n_ack = 0;
    for (int g = 1; g <= 20; g++) begin
      @(negedge clk_i);
      if (!s_stb_o) n_low++;
      if (m0_ack_o || m1_ack_o) n_ack++;
      if (m1_err_o) n_err++;
      if (m0_err_o) begin
        n_err++;
        first_err = g;
        break;
      end
    end
    check("to.ack", 32'(n_ack), 32'd0);
`ifdef WB_ARB_TIMEOUT_EN
    check("to.err_cycle", 32'(first_err), 32'd8);
    check("to.err_count", 32'(n_err), 32'd1);
    check("to.stb_held", 32'(n_low), 32'd0);
    @(posedge clk_i); #1;
    {m0_cyc_i, m0_stb_i} = 2'b00;
    @(negedge clk_i);
    check("to.gap", 32'({s_cyc_o, s_stb_o, m0_err_o}), 32'd0);
`else
    check("to.no_err", 32'(n_err), 32'd0);
    check("to.grant_held", 32'(n_low), 32'd0);
    @(posedge clk_i); #1;
    man_ack = 1'b1;
    @(negedge clk_i);
    check("to.late_ack", 32'({m0_ack_o, m1_ack_o}), 32'd2);
    @(posedge clk_i); #1;
    man_ack = 1'b0;
    {m0_cyc_i, m0_stb_i} = 2'b00;
    @(negedge clk_i);
    check("to.gap", 32'({s_cyc_o, s_stb_o}), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the number of granted cycles without s_ack_i before an error is issued (range 2..65535).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  asynchronous active-low reset.
REQ-004 SHALL have master-0 (instruction) ports m0_cyc_i, m0_stb_i, m0_we_i (input, 1 each), m0_sel_i (input, 4), m0_addr_i (input, 32) and m0_data_i (input, 32).
REQ-005 SHALL have master-0 return ports m0_data_o (output, 32), m0_ack_o (output, 1) and m0_err_o (output, 1).
REQ-006 SHALL have master-1 (data) ports identical to REQ-004/005 with prefix m1_.
REQ-007 SHALL have slave ports s_cyc_o, s_stb_o, s_we_o (output, 1 each), s_sel_o (output, 4), s_addr_o (output, 32) and s_data_o (output, 32).
REQ-008 SHALL have slave return ports s_data_i (input, 32) and s_ack_i (input, 1); the slave is the on-chip RAM wrapper, which acks once per stb/cyc rising edge.

Function
REQ-009 SHALL implement states IDLE, GNT0, GNT1 and GAP.
REQ-010 SHALL define req0 = m0_cyc_i & m0_stb_i and req1 = m1_cyc_i & m1_stb_i.
REQ-011 In IDLE, SHALL move to GNT0 or GNT1 on the next edge when any reqN is high; slave request outputs stay low in IDLE (1-cycle arbitration latency).
REQ-012 SHALL arbitrate round-robin: with both requests high, grant the master not recorded in last_grant; with one request high, grant that master.
REQ-013 SHALL update last_grant to the granted master on each IDLE->GNTx transition.
REQ-014 In GNTx, SHALL drive s_cyc_o/s_stb_o = mx_cyc_i & mx_stb_i, and drive s_we_o, s_sel_o, s_addr_o and s_data_o combinationally from master x.
REQ-015 In states other than GNTx, SHALL drive all s_* outputs to 0.
REQ-016 SHALL drive m0_data_o = m1_data_o = s_data_i at all times.
REQ-017 SHALL set mx_ack_o = s_ack_i only in GNTx, same cycle (zero added latency); the non-granted master's ack is 0.
REQ-018 On s_ack_i in GNTx, SHALL move to GAP; GAP lasts exactly 1 cycle with s_cyc_o = s_stb_o = 0, then returns to IDLE. This guarantees a fresh request rising edge at the slave.
REQ-019 In GNTx, when mx_cyc_i falls without s_ack_i (abort), SHALL move to GAP, ack nothing and give no error.
REQ-020 SHALL ignore s_ack_i in IDLE and GAP; no master sees that ack.
REQ-021 SHALL never switch grant mid-transaction, whatever the other master requests.
REQ-022 Simultaneous s_ack_i and abort SHALL be treated as ack.

Reset
REQ-023 On rst_n_i low, SHALL force immediately: state IDLE, last_grant = 1 (so master 0 wins the first tie), timeout counter 0, all s_* outputs 0, all ack/err outputs 0.
REQ-024 Reset asserted mid-transaction SHALL drop s_cyc_o/s_stb_o with no ack or err; after release, arbitration restarts from IDLE.

Configuration
REQ-025 With macro WB_ARB_TIMEOUT_EN defined, SHALL include a 16-bit counter that clears on entry to GNTx and increments each GNTx cycle without s_ack_i.
REQ-026 With WB_ARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES-1 without ack, SHALL assert mx_err_o for exactly that cycle (no ack) and move to GAP.
REQ-027 Without WB_ARB_TIMEOUT_EN, SHALL contain no counter, tie m0_err_o and m1_err_o to 0, and wait for ack indefinitely.

Verification
REQ-028 Single read: m0 requests addr 0x0000_0010, slave acks 1 cycle after s_stb_o -> s_addr_o = 0x10; m0_ack_o high 1 cycle with m0_data_o = s_data_i; s_stb_o low the cycle after ack.
REQ-029 Tie after reset: m0 and m1 request on the same edge -> m0 is served first, then m1 starts after GAP+IDLE (4 cycles between s_stb_o rising edges with a 1-cycle-ack slave).
REQ-030 Back-to-back contention: both masters hold requests for 4 transactions each -> grants alternate 0,1,0,1...; no master is starved.
REQ-031 Write routing: m1 writes 0xDEADBEEF with sel 4'b0011 to addr 0x0000_0104 -> s_we_o = 1, s_sel_o = 0011, s_data_o = 0xDEADBEEF; m0_ack_o stays 0.
REQ-032 Abort and reset: m0 drops cyc 1 cycle into grant -> GAP then IDLE with no ack; rst_n_i pulsed low mid-grant -> all outputs 0 immediately.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES = 8): slave never acks -> m0_err_o high on the 8th granted cycle, followed by GAP; without the macro -> no err and the grant is held.
